// File: rtl/adex_neuron_array_tdm.sv
// Purpose : N-neuron time-multiplexed AdEx core, one shared datapath sweeping per-neuron V/w state.
// Latency : busy for N_NEURONS cycles after step; a spike becomes visible on spk_valid one cycle after its update.
// Backpr. : spikes queue in a FIFO_DEPTH event FIFO; push on full without a same-cycle pop is lost and sets drop.
// Build   : define REFRACTORY_EN to add per-neuron refractory counters (REF_STEPS sweeps).

module adex_spike_fifo #(
  parameter int DW    = 2,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  output logic [DW-1:0] rd_dat,
  output logic          empty,
  output logic          full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_rd, do_wr;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CNT_FULL);
  assign rd_dat = mem[rd_ptr];

  // A write into a full FIFO is still accepted when the head leaves in the same cycle.
  always_comb begin
    do_rd = rd_en && !empty;
    do_wr = wr_en && (!full || do_rd);
  end

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module adex_neuron_array_tdm #(
  parameter int N_NEURONS  = 4,
  parameter int W          = 16,
  parameter int FRAC       = 8,
  parameter int LUT_DEPTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TAU_SH     = 3,
  parameter int TAUW_SH    = 6,
  parameter int A_SH       = 2,
  parameter int EL_MV      = -70,
  parameter int VT_MV      = -50,
  parameter int VPEAK_MV   = 0,
  parameter int VRESET_MV  = -58,
  parameter int B_MV       = 1
`ifdef REFRACTORY_EN
  , parameter int REF_STEPS = 2
`endif
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      step,
  input  logic                                      cur_we,
  input  logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] cur_addr,
  input  logic [W-1:0]                              cur_data,
  output logic                                      busy,
  output logic                                      spk_valid,
  output logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] spk_id,
  input  logic                                      spk_ready,
  output logic                                      overrun,
  output logic                                      drop,
  output logic [W-1:0]                              v_mon
);
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int XW = W + 4;
  localparam int ONE = 2 ** FRAC;
  localparam int EL_I = EL_MV * ONE;
  localparam int VLO_I = (VT_MV - 8) * ONE;
  localparam int VMAX_I = (2 ** (W - 1)) - 1;
  localparam int VMIN_I = -(2 ** (W - 1));
  localparam int VPEAK_I = VPEAK_MV * ONE;
  localparam int VRESET_I = VRESET_MV * ONE;
  localparam int B_I = B_MV * ONE;
  localparam int LMAX_I = LUT_DEPTH - 1;

  localparam logic signed [W-1:0]  EL      = EL_I[W-1:0];
  localparam logic signed [W-1:0]  VRESET  = VRESET_I[W-1:0];
  localparam logic signed [XW-1:0] EL_X    = EL_I[XW-1:0];
  localparam logic signed [XW-1:0] VLO_X   = VLO_I[XW-1:0];
  localparam logic signed [XW-1:0] VMAX_X  = VMAX_I[XW-1:0];
  localparam logic signed [XW-1:0] VMIN_X  = VMIN_I[XW-1:0];
  localparam logic signed [XW-1:0] VPEAK_X = VPEAK_I[XW-1:0];
  localparam logic signed [XW-1:0] B_X     = B_I[XW-1:0];
  localparam logic signed [XW-1:0] LMAX_X  = LMAX_I[XW-1:0];
  localparam logic [NW-1:0]        K_LAST  = NW'(N_NEURONS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  // DT*exp((V-VT)/DT) with DT = 2 mV, index i <-> V = VT-8mV+i mV, Q.8, rounded, clipped at +max.
  function automatic logic [W-1:0] exp_lut(input logic [4:0] i);
    case (i)
      5'd0:  return 16'd9;
      5'd1:  return 16'd15;
      5'd2:  return 16'd25;
      5'd3:  return 16'd42;
      5'd4:  return 16'd69;
      5'd5:  return 16'd114;
      5'd6:  return 16'd188;
      5'd7:  return 16'd311;
      5'd8:  return 16'd512;
      5'd9:  return 16'd844;
      5'd10: return 16'd1392;
      5'd11: return 16'd2295;
      5'd12: return 16'd3783;
      5'd13: return 16'd6237;
      5'd14: return 16'd10284;
      5'd15: return 16'd16955;
      5'd16: return 16'd27954;
      default: return 16'd32767;
    endcase
  endfunction

  function automatic logic signed [XW-1:0] sx(input logic signed [W-1:0] a);
    return {{(XW - W){a[W-1]}}, a};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] a);
    if (a > VMAX_X) return VMAX_X[W-1:0];
    if (a < VMIN_X) return VMIN_X[W-1:0];
    return a[W-1:0];
  endfunction

  logic signed [W-1:0]  v_r [N_NEURONS];
  logic signed [W-1:0]  w_r [N_NEURONS];
  logic signed [W-1:0]  i_r [N_NEURONS];
  state_t               state;
  logic [NW-1:0]        k;

  logic signed [XW-1:0] v_x, w_x, i_x, diff, idx_x, e_x, dv, dw, v_sum, w_sum;
  logic [4:0]           lut_idx;
  logic                 spike_raw, fire, in_ref;
  logic signed [W-1:0]  v_new, w_new;
  logic                 push, pop, fifo_empty, fifo_full;

`ifdef REFRACTORY_EN
  localparam int RCW = $clog2(REF_STEPS + 1);
  localparam logic [RCW-1:0] REF_LOAD = REF_STEPS[RCW-1:0];
  logic [RCW-1:0] ref_r [N_NEURONS];
  assign in_ref = (ref_r[k] != '0);
`else
  assign in_ref = 1'b0;
`endif

  // Shared AdEx datapath for the neuron selected by k, evaluated at W+4 bits.
  always_comb begin
    v_x   = sx(v_r[k]);
    w_x   = sx(w_r[k]);
    i_x   = sx(i_r[k]);
    diff  = v_x - EL_X;
    idx_x = (v_x - VLO_X) >>> FRAC;
    if (idx_x[XW-1])          lut_idx = '0;
    else if (idx_x > LMAX_X)  lut_idx = LMAX_X[4:0];
    else                      lut_idx = idx_x[4:0];
    e_x       = {{(XW - W){1'b0}}, exp_lut(lut_idx)};
    dv        = (e_x - diff - w_x + i_x) >>> TAU_SH;
    dw        = ((diff >>> A_SH) - w_x) >>> TAUW_SH;
    v_sum     = v_x + dv;
    spike_raw = (v_sum >= VPEAK_X);
    fire      = spike_raw && !in_ref;
    w_sum     = w_x + dw + (fire ? B_X : '0);
    v_new     = (fire || in_ref) ? VRESET : sat(v_sum);
    w_new     = sat(w_sum);
  end

  assign push = (state == SWEEP) && fire;
  assign pop  = spk_valid && spk_ready;
  assign spk_valid = !fifo_empty;

  adex_spike_fifo #(.DW(NW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push),
    .wr_dat (k),
    .rd_en  (spk_ready),
    .rd_dat (spk_id),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Sweep FSM, per-neuron state write-back, current writes and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      drop    <= 1'b0;
      v_mon   <= EL;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_r[i] <= EL;
        w_r[i] <= '0;
        i_r[i] <= '0;
`ifdef REFRACTORY_EN
        ref_r[i] <= '0;
`endif
      end
    end else begin
      if (cur_we && (cur_addr <= K_LAST)) i_r[cur_addr] <= cur_data;
      if (push && fifo_full && !pop) drop <= 1'b1;
      case (state)
        IDLE: begin
          if (step) begin
            state <= SWEEP;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (step) overrun <= 1'b1;
          v_r[k] <= v_new;
          w_r[k] <= w_new;
          v_mon  <= v_new;
`ifdef REFRACTORY_EN
          if (in_ref)    ref_r[k] <= ref_r[k] - 1'b1;
          else if (fire) ref_r[k] <= REF_LOAD;
`endif
          if (k == K_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adex_neuron_array_tdm.sv
// Directed bench for adex_neuron_array_tdm: integer AdEx reference model plus a
// cycle-accurate queue of expected spike events checked against the FIFO head.
`timescale 1ns/1ps
module tb_adex_neuron_array_tdm;
  localparam int N = 4, W = 16, NW = 2, DEPTH = 4, LUTD = 32;
  localparam int EL = -70 * 256, VT = -50 * 256, VRST = -58 * 256, BV = 256;
`ifdef REFRACTORY_EN
  localparam int REF_STEPS = 2;
`endif

  logic clk = 1'b0;
  logic rst, step, cur_we, spk_ready;
  logic [NW-1:0] cur_addr;
  logic [W-1:0]  cur_data;
  logic busy, spk_valid, overrun, drop;
  logic [NW-1:0] spk_id;
  logic [W-1:0]  v_mon;

  always #5 clk = ~clk;

  adex_neuron_array_tdm dut (
    .clk(clk), .rst(rst), .step(step), .cur_we(cur_we), .cur_addr(cur_addr),
    .cur_data(cur_data), .busy(busy), .spk_valid(spk_valid), .spk_id(spk_id),
    .spk_ready(spk_ready), .overrun(overrun), .drop(drop), .v_mon(v_mon)
  );

  int n_chk = 0, n_fail = 0;
  int mv[N], mw[N], mi[N], mref[N];
  int lut[LUTD];
  int m_q[$];
  bit m_drop, m_ovr;
  bit pend_push;
  int pend_id;
  int n_fullpp;
  bit rdy_on_fire;
  int step_no;
  int log_step[$], log_id[$];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int sat16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = EL; mw[i] = 0; mi[i] = 0; mref[i] = 0;
    end
    m_q.delete();
    m_drop = 0; m_ovr = 0; pend_push = 0;
  endtask

  // Reference AdEx update of neuron k from the model state.
  task automatic model_neuron(input int k, output int vexp, output bit fire);
    int d, idx, e, dv, dw, vn;
    d   = mv[k] - EL;
    idx = (mv[k] - (VT - 8 * 256)) >>> 8;
    if (idx < 0) idx = 0;
    if (idx > LUTD - 1) idx = LUTD - 1;
    e   = lut[idx];
    dv  = (-d + e - mw[k] + mi[k]) >>> 3;
    dw  = ((d >>> 2) - mw[k]) >>> 6;
    vn  = mv[k] + dv;
    fire = (vn >= 0);
    if (mref[k] > 0) begin
      fire = 0; mv[k] = VRST; mw[k] = sat16(mw[k] + dw); mref[k]--;
    end else if (fire) begin
      mv[k] = VRST; mw[k] = sat16(mw[k] + dw + BV);
`ifdef REFRACTORY_EN
      mref[k] = REF_STEPS;
`endif
    end else begin
      mv[k] = sat16(vn); mw[k] = sat16(mw[k] + dw);
    end
    vexp = mv[k];
  endtask

  // One clock: advance the expected-event queue by what the edge does, then compare flags and head.
  task automatic tick();
    bit pop_now, rst_now;
    int sz;
    pop_now = (m_q.size() != 0) && spk_ready;
    rst_now = rst;
    if (spk_valid && spk_ready) begin
      log_step.push_back(step_no);
      log_id.push_back(int'(spk_id));
    end
    @(negedge clk);
    if (rst_now) model_reset();
    else begin
      sz = m_q.size();
      if (pop_now) void'(m_q.pop_front());
      if (pend_push) begin
        if (pop_now && sz == DEPTH) n_fullpp++;
        if (m_q.size() < DEPTH) m_q.push_back(pend_id);
        else m_drop = 1;
      end
    end
    pend_push = 0;
    check("spk_valid", spk_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("spk_id", spk_id, m_q[0]);
    check("drop", drop, m_drop);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic write_cur(input int addr, input int val);
    cur_we = 1; cur_addr = addr[NW-1:0]; cur_data = val[W-1:0];
    tick();
    cur_we = 0;
    mi[addr] = val;
  endtask

  // One sweep; optional current write, second step, or reset at sweep cycle k (-1 = none).
  task automatic do_step(input int wr_k, input int wr_addr, input int wr_val, input int s2_k, input int rst_k);
    int vexp;
    bit fire;
    step = 1;
    tick();
    step = 0;
    step_no++;
    check("busy_start", busy, 1);
    for (int k = 0; k < N; k++) begin
      if (rst_k == k) begin
        rst = 1;
        tick();
        rst = 0;
        check("abort_busy", busy, 0);
        check("abort_v_mon", $signed(v_mon), EL);
        return;
      end
      if (s2_k == k) begin step = 1; m_ovr = 1; end
      if (wr_k == k) begin cur_we = 1; cur_addr = wr_addr[NW-1:0]; cur_data = wr_val[W-1:0]; end
      model_neuron(k, vexp, fire);
      if (wr_k == k) mi[wr_addr] = wr_val;
      if (fire) begin pend_push = 1; pend_id = k; end
      if (rdy_on_fire && fire) spk_ready = 1;
      tick();
      if (rdy_on_fire) spk_ready = 0;
      step = 0; cur_we = 0;
      check("v_mon", $signed(v_mon), vexp);
      check("w_state", $signed(dut.w_r[k]), mw[k]);
      if (fire) check("v_after_spike", $signed(v_mon), VRST);
      check("busy", busy, k != N - 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, isi_a, isi_b;
    for (int i = 0; i < LUTD; i++) begin
      real r;
      r = 512.0 * $exp((i - 8) / 2.0);
      lut[i] = (r > 32767.0) ? 32767 : $rtoi(r + 0.5);
    end
    rst = 1; step = 0; cur_we = 0; cur_addr = '0; cur_data = '0; spk_ready = 1;
    rdy_on_fire = 0; n_fullpp = 0; step_no = 0;
    model_reset();
    tick(); tick();
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_v_mon", $signed(v_mon), EL);
    check("rst_spk_id", spk_id, 0);

    // Quiescent network: no input, no spikes
    for (int s = 0; s < 10; s++) do_step(-1, -1, 0, -1, -1);
    check("quiet_no_spikes", log_id.size(), 0);

    // Neuron 1 driven: spikes from ID 1 only, adapting intervals
    write_cur(1, 30 * 256);
    guard = 0;
    while (log_id.size() < 5 && guard < 300) begin
      do_step(-1, -1, 0, -1, -1);
      guard++;
    end
    check("adapt_spike_count", log_id.size() >= 5, 1);
    foreach (log_id[i]) check("adapt_id", log_id[i], 1);
    if (log_step.size() >= 5) begin
      isi_a = log_step[1] - log_step[0];
      isi_b = log_step[4] - log_step[3];
      check("isi_grows", isi_b > isi_a, 1);
    end

    // All driven, consumer stalled: FIFO fills in ID order, later spikes dropped
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < N; i++) write_cur(i, 40 * 256);
    spk_ready = 0;
    guard = 0;
    while (!m_drop && guard < 100) begin
      do_step(-1, -1, 0, -1, -1);
      guard++;
    end
    check("drop_set", drop, 1);
    log_id.delete(); log_step.delete();
    rdy_on_fire = 1;
    guard = 0;
    while (n_fullpp == 0 && guard < 50) begin
      do_step(-1, -1, 0, -1, -1);
      guard++;
    end
    rdy_on_fire = 0;
    spk_ready = 1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    check("drain_count", log_id.size() >= 4, 1);
    for (int i = 0; i < 4; i++) if (i < log_id.size()) check("drain_order", log_id[i], i);

    // Step during a sweep
    do_step(-1, -1, 0, 1, -1);
    check("overrun_set", overrun, 1);
    tick();
    check("no_extra_sweep", busy, 0);

    // Reset in sweep cycle 2, then a clean sweep from rest
    do_step(-1, -1, 0, -1, 2);
    check("abort_overrun", overrun, 0);
    check("abort_drop", drop, 0);
    do_step(-1, -1, 0, -1, -1);

    // Current writes during a sweep: ahead of neuron 3, and same cycle as neuron 0
    do_step(1, 3, 20 * 256, -1, -1);
    do_step(0, 0, 20 * 256, -1, -1);
    do_step(-1, -1, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
